// File: rtl/axis_frame_monitor.sv
// rtl/axis_frame_monitor.sv - passive AXI-Stream video frame monitor: frame/line geometry, SOF/EOF and handshake checks
// Optional frame checksum output: define AXIS_FRAME_MONITOR_CHECKSUM_EN.
module axis_frame_monitor #(
  parameter int T_DATA_WIDTH = 64,
  parameter int T_USER_WIDTH = 4,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    aclk,
  input  logic                    aclk_reset,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  input  logic [T_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [T_USER_WIDTH-1:0] s_axis_tuser,
  input  logic                    cfg_enable,
  input  logic [CNT_WIDTH-1:0]    cfg_line_beats,
  input  logic [CNT_WIDTH-1:0]    cfg_lines,
  input  logic                    err_clear,
  output logic                    frame_done,
  output logic [31:0]             frame_cnt,
  output logic [15:0]             dropped_beats,
  output logic [4:0]              err_flags
`ifdef AXIS_FRAME_MONITOR_CHECKSUM_EN
  ,
  output logic [T_DATA_WIDTH-1:0] frame_checksum
`endif
);

  typedef enum logic [1:0] {ST_DISABLED, ST_WAIT_SOF, ST_IN_FRAME} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == {CNT_WIDTH{1'b1}}) ? v : v + CNT_ONE;
  endfunction

  state_t                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    beat_cnt_q, beat_cnt_d;
  logic [CNT_WIDTH-1:0]    line_cnt_q, line_cnt_d;
  logic                    frame_done_q, frame_done_d;
  logic [31:0]             frame_cnt_q, frame_cnt_d;
  logic [15:0]             dropped_q, dropped_d;
  logic [4:0]              err_q, err_d;
  logic                    hold_valid_q, hold_valid_d;
  logic [T_DATA_WIDTH-1:0] hold_data_q, hold_data_d;
  logic [T_USER_WIDTH-1:0] hold_user_q, hold_user_d;
  logic                    hold_last_q, hold_last_d;
  logic [T_DATA_WIDTH-1:0] acc_q, acc_d;
  logic [T_DATA_WIDTH-1:0] csum_q, csum_d;

  logic                    accept, sof, eof, active, in_frame, frame_beat, drop_beat, line_end;
  logic [CNT_WIDTH-1:0]    cur_beat, cur_line;
  logic [4:0]              new_err;

  always_comb begin
    accept     = s_axis_tvalid & s_axis_tready;
    sof        = s_axis_tuser[0];
    eof        = s_axis_tuser[1];
    active     = cfg_enable && (state_q != ST_DISABLED);
    in_frame   = (state_q == ST_IN_FRAME);
    frame_beat = active && accept && (sof || in_frame);
    drop_beat  = active && accept && !in_frame && !sof;
    // A SOF beat always counts as beat 0 of line 0, including a restart mid-frame
    cur_beat   = sof ? '0 : beat_cnt_q;
    cur_line   = sof ? '0 : line_cnt_q;
    line_end   = (cur_line == cfg_lines - CNT_ONE);

    new_err = '0;
    if (drop_beat && eof) new_err[4] = 1'b1;
    if (frame_beat) begin
      if (in_frame && sof) new_err[0] = 1'b1;
      if (cfg_line_beats != '0) begin
        if (s_axis_tlast && (cur_beat != cfg_line_beats - CNT_ONE)) new_err[1] = 1'b1;
        if (!s_axis_tlast && (cur_beat == cfg_line_beats))          new_err[1] = 1'b1;
      end
      if ((cfg_lines != '0) && (eof != (s_axis_tlast && line_end))) new_err[2] = 1'b1;
    end
    if (active && hold_valid_q &&
        (!s_axis_tvalid || (s_axis_tdata != hold_data_q) ||
         (s_axis_tuser != hold_user_q) || (s_axis_tlast != hold_last_q)))
      new_err[3] = 1'b1;

    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    line_cnt_d = line_cnt_q;
    if (!cfg_enable) begin
      state_d    = ST_DISABLED;
      beat_cnt_d = '0;
      line_cnt_d = '0;
    end else begin
      case (state_q)
        ST_DISABLED: state_d = ST_WAIT_SOF;
        default: begin
          if (frame_beat) begin
            beat_cnt_d = s_axis_tlast ? '0 : sat_inc(cur_beat);
            line_cnt_d = s_axis_tlast ? sat_inc(cur_line) : cur_line;
            state_d    = eof ? ST_WAIT_SOF : ST_IN_FRAME;
          end
        end
      endcase
    end

    frame_done_d = frame_beat && eof;
    frame_cnt_d  = frame_cnt_q + {31'b0, frame_done_d};

    dropped_d = dropped_q;
    if (err_clear)                                dropped_d = '0;
    else if (drop_beat && (dropped_q != 16'hFFFF)) dropped_d = dropped_q + 16'd1;
    err_d = err_clear ? 5'b0 : (err_q | new_err);

    hold_valid_d = s_axis_tvalid & ~s_axis_tready;
    hold_data_d  = s_axis_tdata;
    hold_user_d  = s_axis_tuser;
    hold_last_d  = s_axis_tlast;

    acc_d  = acc_q;
    csum_d = csum_q;
    if (frame_beat) acc_d = (sof ? '0 : acc_q) ^ s_axis_tdata;
    if (frame_done_d) csum_d = acc_d;
  end

  always_ff @(posedge aclk) begin
    if (aclk_reset) begin
      state_q      <= ST_DISABLED;
      beat_cnt_q   <= '0;
      line_cnt_q   <= '0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
      dropped_q    <= '0;
      err_q        <= '0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      hold_user_q  <= '0;
      hold_last_q  <= 1'b0;
      acc_q        <= '0;
      csum_q       <= '0;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      line_cnt_q   <= line_cnt_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
      dropped_q    <= dropped_d;
      err_q        <= err_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      hold_user_q  <= hold_user_d;
      hold_last_q  <= hold_last_d;
      acc_q        <= acc_d;
      csum_q       <= csum_d;
    end
  end

  assign frame_done    = frame_done_q;
  assign frame_cnt     = frame_cnt_q;
  assign dropped_beats = dropped_q;
  assign err_flags     = err_q;

`ifdef AXIS_FRAME_MONITOR_CHECKSUM_EN
  assign frame_checksum = csum_q;
`else
  logic unused_csum;
  assign unused_csum = ^{acc_q, csum_q};
`endif

endmodule
